reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_sb_if.sv | 22 ++
 rtl/reg_file_scoreboard.sv | 47 ++++
 rtl/reg_file_sb.sv | 73 +++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and types for the scoreboarded register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   idx_bits()           : index width for a register count
//   reg_idx_t / xlen_t   : register index and data word at the defaults
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF = idx_bits(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: link between the register file and its pending scoreboard.
//   set_v/set_idx : issue strobe, marks a destination register pending
//   clr_v/clr_idx : writeback strobe, clears the pending mark
//   pending       : one bit per register, bit 0 is never set
//   cnt           : number of set pending bits
// Strobes are sampled on the rising clock; there is no backpressure, so the
// master side owns the strobes and the slave side owns pending/cnt.
interface reg_file_sb_if #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 6
) ();
  logic             set_v;
  logic [AW-1:0]    set_idx;
  logic             clr_v;
  logic [AW-1:0]    clr_idx;
  logic [NREGS-1:0] pending;
  logic [CW-1:0]    cnt;

  modport master (output set_v, set_idx, clr_v, clr_idx, input pending, cnt);
  modport slave  (input set_v, set_idx, clr_v, clr_idx, output pending, cnt);
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: pending bitmap with a running population count.
//   clk, rst : clock, asynchronous active-high reset
//   sb       : slave side of reg_file_sb_if (strobes in, pending/cnt out)
module reg_file_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  sb
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_hit, clr_hit, inc, dec;

  always_comb begin
    pending_d = pending_q;
    set_hit   = sb.set_v && (sb.set_idx != '0);
    clr_hit   = sb.clr_v && (sb.clr_idx != '0);
    // Clear first so a same-register issue overrides the writeback.
    if (clr_hit) pending_d[sb.clr_idx] = 1'b0;
    if (set_hit) pending_d[sb.set_idx] = 1'b1;
    // Count only real bit transitions; this keeps cnt equal to popcount.
    inc = set_hit && !pending_q[sb.set_idx];
    dec = clr_hit && pending_q[sb.clr_idx] &&
          !(set_hit && (sb.set_idx == sb.clr_idx));
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sb.pending = pending_q;
  assign sb.cnt     = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write bypass and a pending scoreboard.
//   clk, rst          : clock, asynchronous active-high reset
//   we/waddr/wdata    : writeback port (also clears pending)
//   raddr/rdata/rbusy : NRD packed combinational read ports with busy flag
//   iss_valid/iss_rd  : issue strobe, marks destination pending
//   pend_cnt          : registered count of pending registers
// Register 0 is hardwired to zero and is never pending.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [CW-1:0]     pend_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_hit;

  assign wr_hit = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_sb_if #(.NREGS(NREGS), .AW(AW), .CW(CW)) sb_if ();

  assign sb_if.set_v   = iss_valid;
  assign sb_if.set_idx = iss_rd;
  assign sb_if.clr_v   = we;
  assign sb_if.clr_idx = waddr;
  assign pend_cnt      = sb_if.cnt;

  reg_file_scoreboard #(.NREGS(NREGS), .AW(AW), .CW(CW)) u_sb (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          byp;
    assign ra  = raddr[i*AW +: AW];
    // A same-cycle writeback to this register is forwarded and hides busy.
    assign byp = wr_hit && (waddr == ra);
    assign rdata[i*XLEN +: XLEN] = (ra == '0) ? '0 : (byp ? wdata : regs_q[ra]);
    assign rbusy[i] = (ra != '0) && sb_if.pending[ra] && !byp;
  end

endmodule
